// File: rtl/layer35_train_ctrl.sv
// layer35_train_ctrl: sequences one labelled sample through a 35-neuron layer.
// It accepts a sample, issues a forward strobe and waits SETTLE cycles. It then
// scans the 35 outputs for the argmax. In training mode with a valid label it
// issues a learn strobe against a one-hot target. Last, it reports the result
// and updates the saturating accuracy counters.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   s_valid/s_ready       sample handshake; s_in, s_label, s_train sample payload
//   layer_valid/learn     strobe and learn qualifier to the layer
//   layer_in              registered sample (N elements of DW bits)
//   layer_out             layer outputs (35 elements of DW bits)
//   expected_out          one-hot target (element[label] all-ones)
//   r_valid               one-cycle result pulse
//   r_pred/r_correct/r_bad_label  held result of the last report
//   stat_clear            zero both counters (wins over a same-cycle increment)
//   stat_total/stat_correct  saturating sample / correct-prediction counters
module layer35_train_ctrl #(
  parameter int unsigned N      = 16,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DW     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*DW-1:0]     s_in,
  input  logic [5:0]          s_label,
  input  logic                s_train,
  output logic                layer_valid,
  output logic                layer_learn,
  output logic [N*DW-1:0]     layer_in,
  input  logic [35*DW-1:0]    layer_out,
  output logic [35*DW-1:0]    expected_out,
  output logic                r_valid,
  output logic [5:0]          r_pred,
  output logic                r_correct,
  output logic                r_bad_label,
  input  logic                stat_clear,
  output logic [CNT_W-1:0]    stat_total,
  output logic [CNT_W-1:0]    stat_correct
);

  localparam int unsigned NCLS     = 35;
  localparam int unsigned LAST_IDX = NCLS - 1;
  localparam int unsigned CW       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_WAIT,
    ST_SCAN,
    ST_LEARN,
    ST_REPORT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_nxt;
  logic [5:0]      scan_idx, idx_nxt;
  logic [DW-1:0]   best_val, best_val_nxt;
  logic [5:0]      best_idx, best_idx_nxt;
  logic [5:0]      lbl;
  logic            trn;
  logic            lbl_ok;
  logic            accept;
  logic [DW-1:0]   scan_val;
  logic [DW-1:0]   out_arr [NCLS];
  logic [35*DW-1:0] exp_build;

  assign accept = s_valid && s_ready;

  // Unpack layer outputs so the scan can index one element per cycle.
  always_comb begin
    for (int k = 0; k < int'(NCLS); k++) begin
      out_arr[k] = layer_out[k*DW +: DW];
    end
  end

  assign scan_val = out_arr[scan_idx];

  // One-hot target for the incoming label; an out-of-range label matches nothing.
  always_comb begin
    exp_build = '0;
    for (int k = 0; k < int'(NCLS); k++) begin
      if (s_label == 6'(k)) begin
        exp_build[k*DW +: DW] = {DW{1'b1}};
      end
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    idx_nxt      = scan_idx;
    best_val_nxt = best_val;
    best_idx_nxt = best_idx;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_FWD;
      end
      ST_FWD: begin
        state_nxt = ST_WAIT;
        wait_nxt  = CW'(SETTLE - 1);
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_SCAN;
          idx_nxt   = '0;
        end else begin
          wait_nxt = wait_cnt - CW'(1);
        end
      end
      ST_SCAN: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if (scan_idx == '0 || scan_val > best_val) begin
          best_val_nxt = scan_val;
          best_idx_nxt = scan_idx;
        end
        if (scan_idx == 6'(LAST_IDX)) begin
          state_nxt = (trn && lbl_ok) ? ST_LEARN : ST_REPORT;
        end else begin
          idx_nxt = scan_idx + 6'd1;
        end
      end
      ST_LEARN:  state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      scan_idx     <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      lbl          <= '0;
      trn          <= 1'b0;
      lbl_ok       <= 1'b0;
      s_ready      <= 1'b0;
      layer_valid  <= 1'b0;
      layer_learn  <= 1'b0;
      layer_in     <= '0;
      expected_out <= '0;
      r_valid      <= 1'b0;
      r_pred       <= '0;
      r_correct    <= 1'b0;
      r_bad_label  <= 1'b0;
      stat_total   <= '0;
      stat_correct <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      scan_idx    <= idx_nxt;
      best_val    <= best_val_nxt;
      best_idx    <= best_idx_nxt;
      s_ready     <= (state_nxt == ST_IDLE);
      layer_valid <= (state_nxt == ST_FWD) || (state_nxt == ST_LEARN);
      layer_learn <= (state_nxt == ST_LEARN);
      r_valid     <= (state_nxt == ST_REPORT);

      if (accept) begin
        layer_in     <= s_in;
        lbl          <= s_label;
        trn          <= s_train;
        lbl_ok       <= (s_label < 6'(NCLS));
        expected_out <= exp_build;
      end

      // Result registers load as REPORT is entered so they are valid with r_valid.
      if (state_nxt == ST_REPORT) begin
        r_pred      <= best_idx_nxt;
        r_correct   <= lbl_ok && (best_idx_nxt == lbl);
        r_bad_label <= !lbl_ok;
      end

      // Counters advance at the end of REPORT; a concurrent clear wins.
      if (stat_clear) begin
        stat_total   <= '0;
        stat_correct <= '0;
      end else if (state == ST_REPORT) begin
        if (stat_total != '1) stat_total <= stat_total + CNT_W'(1);
        if (r_correct && stat_correct != '1) stat_correct <= stat_correct + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_layer35_train_ctrl.sv
// Directed bench for layer35_train_ctrl: a 16-bit-counter instance and a
// 2-bit-counter instance run the same samples side by side.
module tb_layer35_train_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 8;

  logic clock = 1'b0;
  logic reset;
  logic s_valid;
  logic [N*DW-1:0] s_in;
  logic [5:0] s_label;
  logic s_train;
  logic [35*DW-1:0] layer_out;
  logic stat_clear;

  logic s_ready, layer_valid, layer_learn, r_valid, r_correct, r_bad_label;
  logic [N*DW-1:0] layer_in;
  logic [35*DW-1:0] expected_out;
  logic [5:0] r_pred;
  logic [15:0] stat_total, stat_correct;

  logic s_ready2, layer_valid2, layer_learn2, r_valid2, r_correct2, r_bad_label2;
  logic [N*DW-1:0] layer_in2;
  logic [35*DW-1:0] expected_out2;
  logic [5:0] r_pred2;
  logic [1:0] stat_total2, stat_correct2;

  int n_vec = 0;
  int n_bad = 0;
  int nv = 0, nl = 0, nr = 0;
  int lat;
  logic [N*DW-1:0] exp_in;
  logic [35*DW-1:0] exp_out;

  always #5 clock = ~clock;

  layer35_train_ctrl #(.N(N), .SETTLE(2), .CNT_W(16), .DW(DW)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_in(s_in), .s_label(s_label), .s_train(s_train),
    .layer_valid(layer_valid), .layer_learn(layer_learn), .layer_in(layer_in),
    .layer_out(layer_out), .expected_out(expected_out),
    .r_valid(r_valid), .r_pred(r_pred), .r_correct(r_correct), .r_bad_label(r_bad_label),
    .stat_clear(stat_clear), .stat_total(stat_total), .stat_correct(stat_correct)
  );

  layer35_train_ctrl #(.N(N), .SETTLE(2), .CNT_W(2), .DW(DW)) dut_sat (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready2),
    .s_in(s_in), .s_label(s_label), .s_train(s_train),
    .layer_valid(layer_valid2), .layer_learn(layer_learn2), .layer_in(layer_in2),
    .layer_out(layer_out), .expected_out(expected_out2),
    .r_valid(r_valid2), .r_pred(r_pred2), .r_correct(r_correct2), .r_bad_label(r_bad_label2),
    .stat_clear(1'b0), .stat_total(stat_total2), .stat_correct(stat_correct2)
  );

  // Strobe and pulse monitor.
  always @(negedge clock) begin
    if (layer_valid) nv++;
    if (layer_valid && layer_learn) nl++;
    if (r_valid) nr++;
  end

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Background level per element with optional peaks at hi_a / hi_b (-1 = none).
  task automatic set_layer(input int hi_a, input int hi_b);
    for (int k = 0; k < 35; k++) layer_out[k*DW +: DW] = 8'(8'h10 + (k % 5));
    if (hi_a >= 0) layer_out[hi_a*DW +: DW] = 8'hF0;
    if (hi_b >= 0) layer_out[hi_b*DW +: DW] = 8'hF0;
  endtask

  // Offer one sample, track latency to r_valid, then step past REPORT.
  task automatic run_sample(input logic [5:0] lbl, input logic trn, input logic clr,
                            output int latency);
    int g;
    g = 0;
    @(negedge clock);
    while (!s_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    check_eq("ready_before_accept", 320'(s_ready), 320'(1));
    exp_in  = {$urandom, $urandom, $urandom, $urandom};
    exp_out = '0;
    if (lbl < 6'd35) exp_out[lbl*DW +: DW] = 8'hFF;
    s_in    = exp_in;
    s_label = lbl;
    s_train = trn;
    s_valid = 1'b1;
    @(posedge clock);
    #1 s_valid = 1'b0;
    nv = 0; nl = 0; nr = 0;
    latency = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check_eq("layer_in", 320'(layer_in), 320'(exp_in));
        check_eq("expected_out", 320'(expected_out), 320'(exp_out));
      end
      if (r_valid) begin
        latency = k;
        break;
      end
    end
    if (clr) stat_clear = 1'b1;
    @(posedge clock);
    #1 stat_clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_in = '0; s_label = '0; s_train = 1'b0;
    stat_clear = 1'b0;
    set_layer(-1, -1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_s_ready", 320'(s_ready), 320'(0));
    check_eq("rst_outs", 320'({layer_valid, layer_learn, r_valid, r_correct, r_bad_label}), 320'(0));
    check_eq("rst_r_pred", 320'(r_pred), 320'(0));
    check_eq("rst_layer_in", 320'(layer_in), 320'(0));
    check_eq("rst_expected", 320'(expected_out), 320'(0));
    check_eq("rst_stats", 320'({stat_total, stat_correct}), 320'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("ready_after_rst", 320'(s_ready), 320'(1));

    // Basic inference, label 7, peak at 7.
    set_layer(7, -1);
    run_sample(6'd7, 1'b0, 1'b0, lat);
    check_eq("inf_latency", 320'(lat), 320'(39));
    check_eq("inf_strobes", 320'(nv), 320'(1));
    check_eq("inf_learns", 320'(nl), 320'(0));
    check_eq("inf_r_valid_cnt", 320'(nr), 320'(1));
    check_eq("inf_pred", 320'(r_pred), 320'(7));
    check_eq("inf_correct", 320'({r_correct, r_bad_label}), 320'(2'b10));
    check_eq("inf_total", 320'(stat_total), 320'(1));
    check_eq("inf_ncorrect", 320'(stat_correct), 320'(1));

    // Training, label 20, peak at 3.
    set_layer(3, -1);
    run_sample(6'd20, 1'b1, 1'b0, lat);
    check_eq("trn_latency", 320'(lat), 320'(40));
    check_eq("trn_strobes", 320'(nv), 320'(2));
    check_eq("trn_learns", 320'(nl), 320'(1));
    check_eq("trn_pred", 320'(r_pred), 320'(3));
    check_eq("trn_correct", 320'(r_correct), 320'(0));
    check_eq("trn_total", 320'(stat_total), 320'(2));
    check_eq("trn_ncorrect", 320'(stat_correct), 320'(1));
    check_eq("trn_exp_hold", 320'(expected_out), 320'(exp_out));

    // Tie between 5 and 30 resolves to 5.
    set_layer(5, 30);
    run_sample(6'd5, 1'b0, 1'b0, lat);
    check_eq("tie_pred", 320'(r_pred), 320'(5));
    check_eq("tie_correct", 320'(r_correct), 320'(1));
    check_eq("tie_stats", 320'({stat_total, stat_correct}), 320'({16'd3, 16'd2}));

    // Bad label 40 in training mode: no learn strobe.
    set_layer(34, -1);
    run_sample(6'd40, 1'b1, 1'b0, lat);
    check_eq("bad_latency", 320'(lat), 320'(39));
    check_eq("bad_strobes", 320'(nv), 320'(1));
    check_eq("bad_learns", 320'(nl), 320'(0));
    check_eq("bad_pred", 320'(r_pred), 320'(34));
    check_eq("bad_flags", 320'({r_correct, r_bad_label}), 320'(2'b01));
    check_eq("bad_stats", 320'({stat_total, stat_correct}), 320'({16'd4, 16'd2}));
    check_eq("sat_total_4", 320'(stat_total2), 320'(3));
    check_eq("sat_correct_4", 320'(stat_correct2), 320'(2));

    // Fifth sample with clear on REPORT; narrow counters stay saturated.
    set_layer(12, -1);
    run_sample(6'd12, 1'b0, 1'b1, lat);
    check_eq("clr_pred", 320'(r_pred), 320'(12));
    check_eq("clr_stats", 320'({stat_total, stat_correct}), 320'(0));
    check_eq("sat_total_5", 320'(stat_total2), 320'(3));
    check_eq("sat_correct_5", 320'(stat_correct2), 320'(3));

    // Reset during SCAN of a training sample.
    set_layer(9, -1);
    @(negedge clock);
    s_in = 128'hA5; s_label = 6'd9; s_train = 1'b1; s_valid = 1'b1;
    @(posedge clock);
    #1 s_valid = 1'b0;
    nv = 0; nl = 0; nr = 0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("midrst_s_ready_low", 320'(s_ready), 320'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("midrst_s_ready", 320'(s_ready), 320'(1));
    repeat (60) @(negedge clock);
    check_eq("midrst_r_valid", 320'(nr), 320'(0));
    check_eq("midrst_learns", 320'(nl), 320'(0));
    check_eq("midrst_stats", 320'({stat_total, stat_correct}), 320'(0));
    check_eq("midrst_sat_stats", 320'({stat_total2, stat_correct2}), 320'(0));
    check_eq("midrst_layer_in", 320'(layer_in), 320'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/layer35_train_ctrl.md
# layer35_train_ctrl

Training/inference sequencer that drives a 35-neuron `neuron_learn` layer from the initiator side. It accepts one labelled sample per handshake and presents it to the layer as a forward pass. It then waits a fixed settle time, scans the 35 layer outputs for the argmax, and, in training mode, drives a one-hot `expected_out` target plus a single learn strobe. Finally it reports the prediction and updates running accuracy counters. It sits between the sample source (testbench or upstream loader) and the output layer of the network.

## Interface
- `N`, 16: inputs per neuron; width of `layer_in`.
- `SETTLE`, 2: cycles waited after the forward strobe before `layer_out` is sampled; legal range 1..15.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `s_valid`  in  1: sample offered.
- `s_ready`  out  1: controller can accept a sample.
- `s_in`  in  N x zero2one_t: sample inputs.
- `s_label`  in  6: target class, 0..34.
- `s_train`  in  1: 1 = train (learn pass), 0 = inference only.
- `layer_valid`  out  1: strobe to the layer.
- `layer_learn`  out  1: learn qualifier to the layer.
- `layer_in`  out  N x zero2one_t: registered sample to the layer.
- `layer_out`  in  35 x zero2one_t: layer outputs.
- `expected_out`  out  35 x zero2one_t: one-hot target to the layer.
- `r_valid`  out  1: one-cycle result pulse.
- `r_pred`  out  6: argmax index.
- `r_correct`  out  1: `r_pred` equals the label and the label is valid.
- `r_bad_label`  out  1: the captured label was at least 35.
- `stat_clear`  in  1: zero both counters.
- `stat_total`  out  CNT_W: samples reported since clear.
- `stat_correct`  out  CNT_W: correct predictions since clear.

## Operation
- **FSM states:** IDLE, FWD, WAIT, SCAN, LEARN, REPORT.
- **IDLE**
  - `s_ready`=1.
  - On `s_valid` the controller registers `s_in` into `layer_in`, and latches label and train.
  - `expected_out` is rebuilt at the same time: element[label] = all-ones, all others 0.
  - If label >= 35, `expected_out` is all zeros and the bad-label flag is set.
  - Next state is FWD.
- **FWD**
  - `layer_valid`=1 and `layer_learn`=0 for exactly one cycle.
  - Next state is WAIT with a counter loaded to SETTLE-1.
- **WAIT**
  - Decrements the counter.
  - Moves to SCAN after SETTLE cycles.
- **SCAN**
  - Sequential argmax, one index per cycle from 0 to 34 (35 cycles).
  - The best value/index register is loaded from index 0; each later index replaces it only if strictly greater (unsigned).
  - Ties resolve to the lowest index.
  - `layer_out` must stay stable during SCAN; the layer holds it until the next strobe.
  - After index 34 the next state is LEARN if train and the label is valid, otherwise REPORT.
- **LEARN**
  - `layer_valid`=1 and `layer_learn`=1 for exactly one cycle.
  - `expected_out` stays stable.
  - Next state is REPORT.
- **REPORT**
  - `r_valid`=1 for one cycle; `r_pred`, `r_correct` and `r_bad_label` are valid and held until the next REPORT.
  - `stat_total` increments and `stat_correct` increments if correct; both saturate at 2^CNT_W-1.
  - Next state is IDLE.
- **Output stability:** `layer_in` and `expected_out` change only on accept.
- **`stat_clear`:** zeros both counters in any state. If it coincides with a REPORT increment, the clear wins and the counters end at 0.

## Timing
- **Accept:** on the edge where `s_valid`&&`s_ready`; call it cycle 0.
- **Cycle schedule:**
  - Cycle 1: FWD.
  - Cycles 2..1+SETTLE: WAIT.
  - Next 35 cycles: SCAN.
  - Then LEARN (train only).
  - Then REPORT.
- **`r_valid` latency:** cycle 38+SETTLE for train, 37+SETTLE for inference; with SETTLE=2 that is 40 and 39.
- **Throughput:** `s_ready` is high only in IDLE, so the minimum sample period is latency+1 cycles.
- **Reset values:**
  - State IDLE.
  - `s_ready`=0 while `reset` is high, then 1 on the first cycle after.
  - `layer_valid`, `layer_learn`, `r_valid`, `r_correct` and `r_bad_label` are 0.
  - `r_pred`=0.
  - `layer_in` and `expected_out` are all zeros.
  - Both counters are 0.
- **Reset mid-operation:** return to IDLE on the next edge. No pending learn strobe, `r_valid` or counter update is issued.

## Test plan
- **Basic inference:** reset, then a sample with label 7, `s_train`=0, and `layer_out`[7] largest. Expect `layer_valid` pulsed once with `layer_learn`=0, `r_valid` at cycle 39 with `r_pred`=7 and `r_correct`=1, and `stat_total`=`stat_correct`=1.
- **Training:** label 20, `s_train`=1, `layer_out`[3] largest. Expect `expected_out`[20]=all-ones and the rest 0, two strobes (the second with `layer_learn`=1), `r_valid` at cycle 40, `r_pred`=3, `r_correct`=0, and `stat_total`+1 with `stat_correct` unchanged.
- **Tie-break:** `layer_out`[5]=`layer_out`[30]=max. Expect `r_pred`=5.
- **Bad label:** label 40 with `s_train`=1. Expect `expected_out` all zeros, no learn strobe, `r_bad_label`=1, `r_correct`=0, and `stat_total`+1.
- **Counter edge cases:** assert `stat_clear` on the REPORT cycle and expect both counters to read 0. With CNT_W=2, run 5 samples and expect `stat_total` to saturate at 3.
- **Reset mid-SCAN:** assert `reset` at cycle 10. Expect no `r_valid`, no learn strobe, counters 0, and `s_ready`=1 on the first cycle after `reset` deasserts.
